// File: rtl/ddr_wr_burst_arbiter.sv
// Round-robin burst arbiter that shares one AXI write port (AW/W) between two capture FIFOs.
// Each client writes into its own circular DDR region and gets a frame_done pulse when the region wraps.
//
// state | meaning
// IDLE  | DDR not calibrated; region counters held at addr_min
// ARB   | sample FIFO levels and pick the next client
// ADDR  | AWVALID asserted, waiting for AWREADY
// DATA  | granted FIFO streams its burst until WLAST
module ddr_wr_burst_arbiter #(
   parameter int                         CTRL_ADDR_WIDTH = 28,
   parameter int                         BURST_LEN       = 8,
   parameter logic [CTRL_ADDR_WIDTH-1:0] C0_BASE_ADDR    = '0,
   parameter logic [CTRL_ADDR_WIDTH-1:0] C1_BASE_ADDR    = '0
) (
   input  logic                       M_AXI_ACLK,
   input  logic                       M_AXI_ARESETN,
   input  logic                       DDR_INIT_DONE,
   input  logic [8:0]                 c0_wfifo_level,
   input  logic [8:0]                 c1_wfifo_level,
   input  logic [23:0]                c0_addr_min,
   input  logic [23:0]                c0_addr_max,
   input  logic [23:0]                c1_addr_min,
   input  logic [23:0]                c1_addr_max,
   output logic [CTRL_ADDR_WIDTH-1:0] M_AXI_AWADDR,
   output logic [3:0]                 M_AXI_AWLEN,
   output logic                       M_AXI_AWVALID,
   input  logic                       M_AXI_AWREADY,
   input  logic                       M_AXI_WREADY,
   input  logic                       M_AXI_WLAST,
   output logic                       c0_wfifo_rd_req,
   output logic                       c1_wfifo_rd_req,
   output logic                       wdata_sel,
   output logic                       c0_frame_done,
   output logic                       c1_frame_done,
   output logic [3:0]                 arb_state
);

   localparam logic [3:0]  S_IDLE   = 4'b0001;
   localparam logic [3:0]  S_ARB    = 4'b0010;
   localparam logic [3:0]  S_ADDR   = 4'b0100;
   localparam logic [3:0]  S_DATA   = 4'b1000;
   localparam logic [8:0]  LVL_THR  = 9'(BURST_LEN);
   localparam logic [23:0] CNT_STEP = 24'(BURST_LEN);

   logic [3:0]                 r_state;
   logic [3:0]                 w_next;
   logic                       r_awvalid;
   logic                       r_sel;
   logic                       r_last_grant;
   logic                       r_fd0;
   logic                       r_fd1;
   logic [CTRL_ADDR_WIDTH-1:0] r_awaddr;
   logic [23:0]                r_cnt0;
   logic [23:0]                r_cnt1;

   logic                       w_elig0;
   logic                       w_elig1;
   logic                       w_any;
   logic                       w_grant;
   logic                       w_hs;
   logic                       w_wrap0;
   logic                       w_wrap1;
   logic                       w_beat;
   logic [CTRL_ADDR_WIDTH-1:0] w_addr0;
   logic [CTRL_ADDR_WIDTH-1:0] w_addr1;

   assign w_elig0 = c0_wfifo_level > LVL_THR;
   assign w_elig1 = c1_wfifo_level > LVL_THR;
   assign w_any   = w_elig0 | w_elig1;
   // on a tie the client that did not win last time gets the bus
   assign w_grant = (w_elig0 & w_elig1) ? ~r_last_grant : w_elig1;
   assign w_hs    = r_awvalid & M_AXI_AWREADY;
   assign w_wrap0 = r_cnt0 >= (c0_addr_max - CNT_STEP);
   assign w_wrap1 = r_cnt1 >= (c1_addr_max - CNT_STEP);
   assign w_addr0 = C0_BASE_ADDR + CTRL_ADDR_WIDTH'({2'b00, r_cnt0, 2'b00});
   assign w_addr1 = C1_BASE_ADDR + CTRL_ADDR_WIDTH'({2'b00, r_cnt1, 2'b00});
   assign w_beat  = M_AXI_WREADY & ~M_AXI_WLAST;

   always_ff @(posedge M_AXI_ACLK) begin
      if (!M_AXI_ARESETN) r_state <= S_IDLE;
      else                r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (DDR_INIT_DONE) w_next = S_ARB;
         S_ARB: begin
            if (!DDR_INIT_DONE) w_next = S_IDLE;
            else if (w_any)     w_next = S_ADDR;
         end
         S_ADDR:  if (w_hs) w_next = S_DATA;
         S_DATA:  if (M_AXI_WLAST) w_next = S_ARB;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge M_AXI_ACLK) begin
      if (!M_AXI_ARESETN) begin
         r_awvalid    <= 1'b0;
         r_sel        <= 1'b0;
         r_last_grant <= 1'b1;
         r_fd0        <= 1'b0;
         r_fd1        <= 1'b0;
         r_awaddr     <= '0;
         r_cnt0       <= c0_addr_min;
         r_cnt1       <= c1_addr_min;
      end else begin
         r_fd0 <= 1'b0;
         r_fd1 <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cnt0 <= c0_addr_min;
               r_cnt1 <= c1_addr_min;
            end
            S_ARB: begin
               if (DDR_INIT_DONE && w_any) begin
                  r_awvalid    <= 1'b1;
                  r_sel        <= w_grant;
                  r_last_grant <= w_grant;
                  r_awaddr     <= w_grant ? w_addr1 : w_addr0;
               end
            end
            S_ADDR: begin
               if (w_hs) begin
                  r_awvalid <= 1'b0;
                  if (r_sel) begin
                     if (w_wrap1) begin
                        r_cnt1 <= c1_addr_min;
                        r_fd1  <= 1'b1;
                     end else begin
                        r_cnt1 <= r_cnt1 + CNT_STEP;
                     end
                  end else begin
                     if (w_wrap0) begin
                        r_cnt0 <= c0_addr_min;
                        r_fd0  <= 1'b1;
                     end else begin
                        r_cnt0 <= r_cnt0 + CNT_STEP;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      c0_wfifo_rd_req = 1'b0;
      c1_wfifo_rd_req = 1'b0;
      if (r_state == S_DATA) begin
         c0_wfifo_rd_req = ~r_sel & w_beat;
         c1_wfifo_rd_req = r_sel & w_beat;
      end
   end

   assign M_AXI_AWADDR  = r_awaddr;
   assign M_AXI_AWLEN   = 4'(BURST_LEN);
   assign M_AXI_AWVALID = r_awvalid;
   assign wdata_sel     = r_sel;
   assign c0_frame_done = r_fd0;
   assign c1_frame_done = r_fd1;
   assign arb_state     = r_state;

endmodule
